// File: rtl/commit_arb.sv
// Round-robin commit arbiter: grants one enabled channel per cycle into a single
// registered output slot and routes in-order responses back via a channel-index FIFO.
module commit_arb #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    ch_req_vaild,
  output logic [NCH-1:0]    ch_req_ready,
  input  logic [NCH*DW-1:0] ch_r_in,
  output logic [NCH-1:0]    ch_rsp_vaild,
  input  logic [NCH-1:0]    ch_rsp_ready,
  output logic              req_vaild,
  input  logic              req_ready,
  output logic [DW-1:0]     r_out,
  input  logic              rsp_vaild,
  output logic              rsp_ready,
  output logic [CW-1:0]     outstanding,
  output logic              rsp_err
);
  localparam int GW = $clog2(NCH);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0]  words [NCH];
  logic [NCH-1:0] elig;
  logic           slot_free, full, empty, accept, pop, found;
  logic [GW-1:0]  grant, last_grant, head;
  logic [GW-1:0]  fifo [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  int             idx;

  for (genvar i = 0; i < NCH; i++) begin : g_words
    assign words[i] = ch_r_in[i*DW +: DW];
  end

  assign elig      = ch_req_vaild & ch_en;
  assign slot_free = !req_vaild || req_ready;
  assign full      = (outstanding == CW'(DEPTH));
  assign empty     = (outstanding == '0);
  // Gated by reset so every output reads 0 while reset is held.
  assign accept    = reset && slot_free && (|elig) && !full;
  assign head      = fifo[rd_ptr];
  assign rsp_ready = !empty && ch_rsp_ready[head];
  assign pop       = rsp_vaild && rsp_ready;

  // Search starts one past the last grant and wraps at NCH.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && elig[idx[GW-1:0]]) begin
        found = 1'b1;
        grant = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    ch_req_ready = '0;
    ch_rsp_vaild = '0;
    if (accept) ch_req_ready[grant] = 1'b1;
    if (!empty) ch_rsp_vaild[head] = rsp_vaild;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_vaild   <= 1'b0;
      r_out       <= '0;
      last_grant  <= GW'(NCH-1);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      rsp_err     <= 1'b0;
    end else begin
      if (accept) begin
        req_vaild  <= 1'b1;
        r_out      <= words[grant];
        last_grant <= grant;
        wr_ptr     <= wr_ptr + 1'b1;
      end else if (req_ready) begin
        req_vaild  <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (rsp_vaild && empty) rsp_err <= 1'b1;
    end
  end

  // Storage is only read while non-empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= grant;
  end
endmodule

// File: tb/tb_commit_arb.sv
// Randomized and directed check of commit_arb against a queue-based reference model.
module tb_commit_arb;
  localparam int NCH = 4, DW = 32, DEPTH = 8, CW = 4;

  logic            clk, reset;
  logic [NCH-1:0]  ch_en, ch_req_vaild, ch_req_ready, ch_rsp_vaild, ch_rsp_ready;
  logic [NCH*DW-1:0] ch_r_in;
  logic            req_vaild, req_ready, rsp_vaild, rsp_ready, rsp_err;
  logic [DW-1:0]   r_out;
  logic [CW-1:0]   outstanding;

  commit_arb #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .ch_req_vaild(ch_req_vaild),
    .ch_req_ready(ch_req_ready), .ch_r_in(ch_r_in), .ch_rsp_vaild(ch_rsp_vaild),
    .ch_rsp_ready(ch_rsp_ready), .req_vaild(req_vaild), .req_ready(req_ready),
    .r_out(r_out), .rsp_vaild(rsp_vaild), .rsp_ready(rsp_ready),
    .outstanding(outstanding), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] words [NCH];

  // reference model state
  int q[$];
  int m_last;
  bit m_vld, m_err;
  logic [DW-1:0] m_rout;

  logic [NCH-1:0] obs_crr, obs_crv;
  logic [CW-1:0]  obs_out;
  logic           obs_rr, obs_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = NCH - 1;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_rout = '0;
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model at posedge.
  task automatic step(input logic [3:0] en, input logic [3:0] vld, input logic rdy,
                      input logic rv, input logic [3:0] crr);
    logic [3:0] elig, e_crr, e_crv;
    logic [1:0] h;
    bit acc, e_rr;
    int g, idx;
    @(negedge clk);
    ch_en = en; ch_req_vaild = vld; req_ready = rdy; rsp_vaild = rv; ch_rsp_ready = crr;
    ch_r_in = {words[3], words[2], words[1], words[0]};
    #1;
    chk("req_vaild", 32'(req_vaild), 32'(m_vld));
    chk("r_out", r_out, m_rout);
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("rsp_err", 32'(rsp_err), 32'(m_err));
    elig = vld & en;
    g = -1;
    acc = (!m_vld || rdy) && (elig != 0) && (q.size() < DEPTH);
    if (acc)
      for (int k = 1; k <= NCH; k++) begin
        idx = (m_last + k) % NCH;
        if (g < 0 && elig[idx[1:0]]) g = idx;
      end
    e_crr = acc ? 4'(1 << g) : 4'b0;
    e_crv = '0; e_rr = 1'b0; h = '0;
    if (q.size() > 0) begin
      h = q[0][1:0];
      e_rr = crr[h];
      if (rv) e_crv = 4'(1 << h);
    end
    chk("ch_req_ready", 32'(ch_req_ready), 32'(e_crr));
    chk("ch_rsp_vaild", 32'(ch_rsp_vaild), 32'(e_crv));
    chk("rsp_ready", 32'(rsp_ready), 32'(e_rr));
    obs_crr = ch_req_ready; obs_crv = ch_rsp_vaild; obs_out = outstanding;
    obs_rr = rsp_ready; obs_err = rsp_err;
    @(posedge clk);
    if (q.size() == 0 && rv) m_err = 1'b1;
    if (q.size() > 0 && rv && e_rr) void'(q.pop_front());
    if (acc) begin
      q.push_back(g);
      m_last = g;
      m_vld  = 1'b1;
      m_rout = words[g];
    end else if (rdy) begin
      m_vld = 1'b0;
    end
  endtask

  // 5 ns low pulse straddling a rising edge; outputs must clear while it is held.
  task automatic async_reset();
    @(negedge clk);
    ch_req_vaild = '0; rsp_vaild = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_req_vaild", 32'(req_vaild), 0);
    chk("rst_r_out", r_out, 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_ch_req_ready", 32'(ch_req_ready), 0);
    chk("rst_ch_rsp_vaild", 32'(ch_rsp_vaild), 0);
    chk("rst_rsp_ready", 32'(rsp_ready), 0);
    model_reset();
    #4 reset = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * DEPTH && q.size() > 0; n++) step(4'h0, 4'h0, 1'b1, 1'b1, 4'hF);
    step(4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    chk("drain_empty", 32'(obs_out), 0);
  endtask

  initial begin
    logic [3:0] prev;
    reset = 1'b1;
    ch_en = '0; ch_req_vaild = '0; ch_rsp_ready = '0; req_ready = 1'b0; rsp_vaild = 1'b0;
    ch_r_in = '0;
    for (int i = 0; i < NCH; i++) words[i] = '0;
    model_reset();
    async_reset();
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);

    // round-robin order with fixed words
    words[0] = 32'h0A95200B; words[1] = 32'h4000D00B;
    words[2] = 32'h3800800B; words[3] = 32'h5880000B;
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
      chk("rr_seq", 32'(obs_crr), 32'(1 << (k % 4)));
    end
    step(4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    chk("rr_last_word", r_out, 32'h0A95200B);
    drain();

    // backpressure until the order FIFO is full
    step(4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
    step(4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
    chk("hold_crr", 32'(obs_crr), 0);
    for (int k = 0; k < 8; k++) step(4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    step(4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
    chk("full_cnt", 32'(obs_out), 8);
    chk("full_crr", 32'(obs_crr), 0);
    step(4'hF, 4'hF, 1'b1, 1'b1, 4'hF);
    chk("full_pop_crr", 32'(obs_crr), 0);
    step(4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    chk("after_pop_grant", 32'(obs_crr != 0), 1);
    drain();

    // in-order response routing
    step(4'hF, 4'b0100, 1'b1, 1'b0, 4'h0);
    step(4'hF, 4'b0001, 1'b1, 1'b0, 4'h0);
    step(4'h0, 4'h0, 1'b1, 1'b1, 4'hF);
    chk("rsp_first", 32'(obs_crv), 32'h4);
    step(4'h0, 4'h0, 1'b1, 1'b1, 4'hF);
    chk("rsp_second", 32'(obs_crv), 32'h1);
    step(4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    chk("rsp_done", 32'(obs_out), 0);

    // head must not advance while the channel stalls
    step(4'hF, 4'b0010, 1'b1, 1'b0, 4'h0);
    step(4'hF, 4'b1000, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      step(4'h0, 4'h0, 1'b1, 1'b1, 4'b1101);
      chk("stall_head", 32'(obs_crv), 32'h2);
    end
    drain();

    // spurious response
    step(4'h0, 4'h0, 1'b1, 1'b1, 4'hF);
    chk("err_rsp_ready", 32'(obs_rr), 0);
    for (int k = 0; k < 3; k++) begin
      step(4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
      chk("err_sticky", 32'(obs_err), 1);
    end

    // enable mask
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      step(4'b1010, 4'hF, 1'b1, 1'b0, 4'h0);
      chk("en_mask", 32'(obs_crr & 4'b0101), 0);
      if (k > 0) chk("en_alt", 32'(obs_crr), (prev == 4'b0010) ? 32'h8 : 32'h2);
      prev = obs_crr;
    end
    drain();

    // reset mid-flight
    for (int k = 0; k < 3; k++) step(4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    async_reset();
    step(4'h0, 4'h0, 1'b1, 1'b1, 4'hF);
    chk("post_rst_rsp", 32'(obs_crv), 0);
    step(4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    chk("post_rst_grant", 32'(obs_crr), 1);
    drain();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NCH; i++) words[i] = $urandom;
      if (n == 300) async_reset();
      step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), 4'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
